// File: rtl/jump_pkg.sv
// jump_pkg: shared state encoding, widths and default tuning values for the jump controller.
package jump_pkg;
    localparam int VW = 11;
    localparam int DW = 11;
    localparam logic [VW-1:0] V_MIN_DEF = 11'd16;
    localparam logic [VW-1:0] V_MAX_DEF = 11'd508;
    localparam logic [VW-1:0] CHARGE_STEP_DEF = 11'd4;
    localparam logic [DW-1:0] TOL_DEF = 11'd24;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHARGE = 3'd1,
        JUMP   = 3'd2,
        LAND   = 3'd3,
        OVER   = 3'd4
    } state_t;
    function automatic logic [DW:0] abs_diff(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
    endfunction
endpackage

// File: rtl/jump_ctrl_if.sv
// jump_ctrl_if: handshake between the jump controller (master) and the jump physics datapath (slave).
interface jump_ctrl_if;
    import jump_pkg::*;
    logic          o_jump_en;
    logic [VW-1:0] o_v_init;
    logic          i_jump_done;
    logic [DW-1:0] i_dist;
    modport master (output o_jump_en, o_v_init, input i_jump_done, i_dist);
    modport slave  (input o_jump_en, o_v_init, output i_jump_done, i_dist);
endinterface

// File: rtl/jump_charge_acc.sv
// jump_charge_acc: clear/step/saturate accumulator that builds the initial jump velocity.
module jump_charge_acc
    import jump_pkg::*;
#(
    parameter logic [VW-1:0] V_MAX = V_MAX_DEF,
    parameter logic [VW-1:0] CHARGE_STEP = CHARGE_STEP_DEF
) (
    input  logic          clk_jump,
    input  logic          en,
    input  logic          clr_i,
    input  logic          step_i,
    output logic [VW-1:0] v_o
);
    logic [VW-1:0] v_q, v_d;
    logic [VW:0]   sum;

    // one extra bit so the add cannot wrap before saturation
    assign sum = {1'b0, v_q} + {1'b0, CHARGE_STEP};
    assign v_d = clr_i ? '0 : !step_i ? v_q : (sum > {1'b0, V_MAX}) ? V_MAX : sum[VW-1:0];
    assign v_o = v_q;

    always_ff @(posedge clk_jump or negedge en) begin
        if (!en) v_q <= '0;
        else     v_q <= v_d;
    end
endmodule

// File: rtl/jump_ctrl.sv
// jump_ctrl: charge/launch/land sequencer with scoring; JUMP_CTRL_TIMEOUT_EN adds a jump watchdog.
module jump_ctrl
    import jump_pkg::*;
#(
    parameter logic [VW-1:0] V_MIN = V_MIN_DEF,
    parameter logic [VW-1:0] V_MAX = V_MAX_DEF,
    parameter logic [VW-1:0] CHARGE_STEP = CHARGE_STEP_DEF,
    parameter logic [DW-1:0] TOL = TOL_DEF
`ifdef JUMP_CTRL_TIMEOUT_EN
    , parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
`endif
) (
    input  logic          clk_jump,
    input  logic          en,
    input  logic          i_press,
    input  logic          i_restart,
    input  logic [DW-1:0] i_target_dist,
    jump_ctrl_if.master   phy,
    output logic [2:0]    o_state,
    output logic [7:0]    o_score,
    output logic          o_hit,
    output logic          o_miss
);
    state_t        state_q;
    logic          press_q, jump_en_q, hit_q, miss_q, timeout;
    logic [7:0]    score_q;
    logic [DW-1:0] target_q, dist_q;
    logic [VW-1:0] v_init;
    logic          rise, hit;

    assign rise = i_press & ~press_q;
    assign hit  = abs_diff(dist_q, target_q) <= {1'b0, TOL};

    jump_charge_acc #(.V_MAX(V_MAX), .CHARGE_STEP(CHARGE_STEP)) u_acc (
        .clk_jump (clk_jump),
        .en       (en),
        .clr_i    (state_q == IDLE && rise),
        .step_i   (state_q == CHARGE && i_press),
        .v_o      (v_init)
    );

`ifdef JUMP_CTRL_TIMEOUT_EN
    logic [15:0] wd_q;
    // zero outside JUMP, so it is already cleared on the first JUMP tick
    always_ff @(posedge clk_jump or negedge en) begin
        if (!en) wd_q <= '0;
        else     wd_q <= (state_q == JUMP) ? wd_q + 16'd1 : '0;
    end
    assign timeout = (wd_q == TIMEOUT_CYCLES - 16'd1);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_jump or negedge en) begin
        if (!en) begin
            state_q   <= IDLE;
            press_q   <= 1'b0;
            jump_en_q <= 1'b0;
            score_q   <= '0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
            target_q  <= '0;
            dist_q    <= '0;
        end else begin
            press_q <= i_press;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            case (state_q)
                IDLE:   if (rise) state_q <= CHARGE;
                CHARGE: if (!i_press) begin
                    if (v_init < V_MIN) state_q <= IDLE;
                    else begin
                        target_q  <= i_target_dist;
                        jump_en_q <= 1'b1;
                        state_q   <= JUMP;
                    end
                end
                JUMP: if (phy.i_jump_done) begin
                    dist_q  <= phy.i_dist;
                    state_q <= LAND;
                end else if (timeout) begin
                    dist_q  <= '1;
                    state_q <= LAND;
                end
                LAND: begin
                    jump_en_q <= 1'b0;
                    if (hit) begin
                        score_q <= (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                        hit_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        miss_q  <= 1'b1;
                        state_q <= OVER;
                    end
                end
                OVER: if (i_restart) begin
                    score_q <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    jump_en_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign phy.o_jump_en = jump_en_q;
    assign phy.o_v_init  = v_init;
    assign o_state       = state_q;
    assign o_score       = score_q;
    assign o_hit         = hit_q;
    assign o_miss        = miss_q;
endmodule
